// File: rtl/avalon_st_symbol_packer.sv
// Packs RATIO narrow Avalon-ST beats of IN_SYMBOLS symbols into one wide beat.
// Packet framing is carried through; a short final word reports unused trailing symbols in out_empty.
module avalon_st_symbol_packer #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int IN_SYMBOLS   = 3,
   parameter int RATIO        = 2,
   localparam int OUT_SYMBOLS = IN_SYMBOLS * RATIO,
   localparam int EMPTY_W     = (OUT_SYMBOLS > 1) ? $clog2(OUT_SYMBOLS) : 1,
   localparam int IN_W        = SYMBOL_WIDTH * IN_SYMBOLS,
   localparam int OUT_W       = SYMBOL_WIDTH * OUT_SYMBOLS
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic [IN_W-1:0]    in_data,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty,
   output logic               sop_error
);

   localparam int CNT_W = $clog2(RATIO);

   logic [CNT_W-1:0]          cnt;
   logic                      accept;
   logic                      last_slot;
   logic                      complete;
   logic [EMPTY_W-1:0]        empty_nxt;
   logic [RATIO-1:0][IN_W-1:0] word;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign last_slot = (cnt == CNT_W'(RATIO - 1));
   assign complete  = accept && (last_slot || in_endofpacket);
   assign empty_nxt = in_endofpacket ? EMPTY_W'((RATIO - 1 - int'(cnt)) * IN_SYMBOLS) : '0;
   assign out_data  = word;

   // Slot 0 lands in the MSBs; a slot-0 write zeroes the rest so short words carry zero padding.
   for (genvar k = 0; k < RATIO; k++) begin : g_slot
      logic [IN_W-1:0] slot_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            slot_q <= '0;
         end else if (accept) begin
            if (cnt == CNT_W'(k))
               slot_q <= in_data;
            else if (cnt == '0)
               slot_q <= '0;
         end
      end
      assign word[RATIO-1-k] = slot_q;
   end

   // While cnt is non-zero out_valid is necessarily low, so one data register serves both roles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt               <= '0;
         out_valid         <= 1'b0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_empty         <= '0;
         sop_error         <= 1'b0;
      end else begin
         sop_error <= accept && in_startofpacket && (cnt != '0);
         if (complete)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            cnt             <= complete ? '0 : cnt + CNT_W'(1);
            out_endofpacket <= complete && in_endofpacket;
            out_empty       <= complete ? empty_nxt : '0;
            if (cnt == '0)
               out_startofpacket <= in_startofpacket;
         end
      end
   end

endmodule

// File: tb/tb_avalon_st_symbol_packer.sv
// Random and directed stimulus against a queue-based packing model; a negedge monitor scores every output word.
module tb_avalon_st_symbol_packer;

   localparam int SYMBOL_WIDTH = 8;
   localparam int IN_SYMBOLS   = 3;
   localparam int RATIO        = 2;
   localparam int IN_W         = SYMBOL_WIDTH * IN_SYMBOLS;
   localparam int OUT_W        = IN_W * RATIO;
   localparam int EMPTY_W      = 3;

   typedef struct packed {
      logic [OUT_W-1:0]   data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } word_t;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               in_ready;
   logic               in_valid;
   logic [IN_W-1:0]    in_data;
   logic               in_startofpacket;
   logic               in_endofpacket;
   logic               out_ready;
   logic               out_valid;
   logic [OUT_W-1:0]   out_data;
   logic               out_startofpacket;
   logic               out_endofpacket;
   logic [EMPTY_W-1:0] out_empty;
   logic               sop_error;

   avalon_st_symbol_packer #(
      .SYMBOL_WIDTH(SYMBOL_WIDTH), .IN_SYMBOLS(IN_SYMBOLS), .RATIO(RATIO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
      .in_data(in_data), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_empty(out_empty), .sop_error(sop_error)
   );

   always #5 clk = ~clk;

   word_t           sb[$];
   logic [IN_W-1:0] cur[$];
   logic            cur_sop = 1'b0;
   logic            exp_ov  = 1'b0;
   logic            exp_se  = 1'b0;
   int              checks  = 0;
   int              errors  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: collect accepted beats of the current word, emit the concatenation when full or at EOP.
   always @(negedge clk) begin
      word_t e;
      word_t w;
      logic  acc;
      if (!reset_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_sop", out_startofpacket, 0);
         chk("rst_eop", out_endofpacket, 0);
         chk("rst_empty", out_empty, 0);
         chk("rst_sop_error", sop_error, 0);
         chk("rst_in_ready", in_ready, 1);
         sb.delete();
         cur.delete();
         exp_ov = 1'b0;
         exp_se = 1'b0;
      end else begin
         chk("out_valid", out_valid, exp_ov);
         chk("in_ready", in_ready, !exp_ov || out_ready);
         chk("sop_error", sop_error, exp_se);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: actual %0h required none at %0t", out_data, $time);
            end else begin
               e = sb.pop_front();
               chk("word_data", out_data, e.data);
               chk("word_sop", out_startofpacket, e.sop);
               chk("word_eop", out_endofpacket, e.eop);
               if (e.eop) chk("word_empty", out_empty, e.empty);
            end
         end
         acc    = in_valid && (!exp_ov || out_ready);
         exp_se = acc && in_startofpacket && (cur.size() != 0);
         exp_ov = exp_ov && !out_ready;
         if (acc) begin
            if (cur.size() == 0) cur_sop = in_startofpacket;
            cur.push_back(in_data);
            if (cur.size() == RATIO || in_endofpacket) begin
               w.data = '0;
               for (int i = 0; i < cur.size(); i++)
                  w.data[OUT_W-1-i*IN_W -: IN_W] = cur[i];
               w.sop   = cur_sop;
               w.eop   = in_endofpacket;
               w.empty = in_endofpacket ? EMPTY_W'((RATIO - cur.size()) * IN_SYMBOLS) : '0;
               sb.push_back(w);
               cur.delete();
               exp_ov = 1'b1;
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic s, input logic e,
                        input logic r);
      @(posedge clk);
      #2;
      in_valid         = v;
      in_data          = d;
      in_startofpacket = s;
      in_endofpacket   = e;
      out_ready        = r;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_data = '0;
      in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;

      drive(1, 24'hAABBCC, 1, 0, 1);
      drive(1, 24'h112233, 0, 1, 1);
      drive(1, 24'h010203, 1, 0, 1);
      drive(1, 24'h040506, 0, 0, 1);
      drive(1, 24'h070809, 0, 1, 1);

      // hold a completed word under backpressure, then release with a beat waiting
      drive(1, 24'hA1A2A3, 1, 0, 1);
      drive(1, 24'hB1B2B3, 0, 0, 1);
      repeat (5) drive(1, 24'hC1C2C3, 1, 0, 0);
      drive(1, 24'hC1C2C3, 1, 0, 1);
      drive(1, 24'hD1D2D3, 0, 1, 1);

      for (int i = 0; i < 8; i++)
         drive(1, IN_W'(24'h100000 + i), (i % 4) == 0, (i % 4) == 3, 1);

      drive(1, 24'h0A0B0C, 1, 0, 1);
      drive(1, 24'h0D0E0F, 1, 1, 1);

      // reset with one beat of a word already captured
      drive(1, 24'h5A5A5A, 1, 0, 1);
      @(posedge clk);
      #2 in_valid = 1'b0; reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      drive(1, 24'h123456, 1, 0, 1);
      drive(1, 24'h789ABC, 0, 1, 1);

      for (int i = 0; i < 2000; i++)
         drive($urandom_range(0, 3) != 0, IN_W'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);

      repeat (6) drive(0, '0, 0, 0, 1);
      @(posedge clk);
      chk("drain_pending_words", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
